conv_loop_sched: RTL and testbench



---
 rtl/conv_sched_pkg.sv | 17 +
 rtl/conv_idx_cnt.sv | 71 +++++++
 rtl/conv_loop_sched.sv | 107 ++++++++++
 tb/tb_conv_loop_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared state encoding, default sizes and stage-vector type for the conv2D
// kernel-loop scheduler.
package conv_sched_pkg;

    localparam int CONV_K_W   = 8;
    localparam int CONV_DEPTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        ZERO  = 2'd3
    } state_t;

    typedef logic [CONV_DEPTH-1:0] stage_vec_t;

endpackage

// File: rtl/conv_idx_cnt.sv
// Nested k1/k2 index counter: latches the trip counts on load and advances one
// inner step per enable, wrapping k2 into k1.
module conv_idx_cnt
    import conv_sched_pkg::*;
#(
    parameter int K_W = CONV_K_W
)
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_i,
    input  logic [K_W-1:0] k1_bound_i,
    input  logic [K_W-1:0] k2_bound_i,
    input  logic           adv_i,
    output logic [K_W-1:0] k1_o,
    output logic [K_W-1:0] k2_o,
    output logic           last_o
);

    logic [K_W-1:0] b1_q, b1_d;
    logic [K_W-1:0] b2_q, b2_d;
    logic [K_W-1:0] k1_q, k1_d;
    logic [K_W-1:0] k2_q, k2_d;
    logic           k1_wrap;
    logic           k2_wrap;

    // Compare against bound-1 so a bound of 2^K_W-1 never needs a wider counter.
    always_comb begin
        k1_wrap = (k1_q == (b1_q - K_W'(1)));
        k2_wrap = (k2_q == (b2_q - K_W'(1)));
    end

    always_comb begin
        b1_d = b1_q;
        b2_d = b2_q;
        k1_d = k1_q;
        k2_d = k2_q;
        if (load_i) begin
            b1_d = k1_bound_i;
            b2_d = k2_bound_i;
            k1_d = '0;
            k2_d = '0;
        end else if (adv_i) begin
            if (k2_wrap) begin
                k2_d = '0;
                k1_d = k1_wrap ? '0 : (k1_q + K_W'(1));
            end else begin
                k2_d = k2_q + K_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            b1_q <= '0;
            b2_q <= '0;
            k1_q <= '0;
            k2_q <= '0;
        end else begin
            b1_q <= b1_d;
            b2_q <= b2_d;
            k1_q <= k1_d;
            k2_q <= k2_d;
        end
    end

    assign k1_o   = k1_q;
    assign k2_o   = k2_q;
    assign last_o = k1_wrap & k2_wrap;

endmodule

// File: rtl/conv_loop_sched.sv
// Sequencer for the flattened k1 x k2 kernel loop: issues one iteration per
// unstalled cycle and tracks per-stage valid/last flags through the pipeline.
module conv_loop_sched
    import conv_sched_pkg::*;
#(
    parameter int K_W   = CONV_K_W,
    parameter int DEPTH = CONV_DEPTH
)
(
    input  logic             ap_clk_i,
    input  logic             ap_rst_i,
    input  logic             ap_start_i,
    input  logic [K_W-1:0]   k1_bound_i,
    input  logic [K_W-1:0]   k2_bound_i,
    input  logic             stall_i,
    output logic             ap_ready_o,
    output logic             ap_done_o,
    output logic             ap_idle_o,
    output logic [K_W-1:0]   k1_o,
    output logic [K_W-1:0]   k2_o,
    output logic [DEPTH-1:0] stage_en_o,
    output logic [DEPTH-1:0] last_en_o,
    output state_t           state_o
);

    // Handshake: ap_start is a level the parent holds until ap_ready; it is only
    // sampled in IDLE on a cycle with stall low, and every output pulse is
    // suppressed while stall is high because nothing moves on such a cycle.

    state_t           state_q, state_d;
    logic [DEPTH-1:0] en_q, en_d;
    logic [DEPTH-1:0] lst_q, lst_d;
    logic             run;
    logic             start_ok;
    logic             bounds_zero;
    logic             issue;
    logic             cnt_last;

    always_comb begin
        run         = (state_q == RUN);
        bounds_zero = (k1_bound_i == '0) | (k2_bound_i == '0);
        start_ok    = (state_q == IDLE) & ap_start_i & ~stall_i;
        issue       = run & ~stall_i;
    end

    conv_idx_cnt #(.K_W(K_W)) u_idx_cnt (
        .clk_i      (ap_clk_i),
        .rst_i      (ap_rst_i),
        .load_i     (start_ok),
        .k1_bound_i (k1_bound_i),
        .k2_bound_i (k2_bound_i),
        .adv_i      (issue),
        .k1_o       (k1_o),
        .k2_o       (k2_o),
        .last_o     (cnt_last)
    );

    always_ff @(posedge ap_clk_i) begin
        if (ap_rst_i) begin
            state_q <= IDLE;
            en_q    <= '0;
            lst_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            lst_q   <= lst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = bounds_zero ? ZERO : RUN;
            RUN:     if (issue && cnt_last) state_d = ap_done_o ? IDLE : DRAIN;
            DRAIN:   if (ap_done_o) state_d = IDLE;
            ZERO:    if (!stall_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage 0 is the iteration presented this cycle, so it comes from the FSM;
    // the registers only ever carry stages 1..DEPTH-1 (bit 0 stays zero).
    always_comb begin
        stage_en_o    = en_q;
        stage_en_o[0] = en_q[0] | run;
        last_en_o     = lst_q;
        last_en_o[0]  = lst_q[0] | (run & cnt_last);
        ap_ready_o    = (issue & cnt_last) | ((state_q == ZERO) & ~stall_i);
        ap_done_o     = (last_en_o[DEPTH-1] & ~stall_i) | ((state_q == ZERO) & ~stall_i);
        ap_idle_o     = (state_q == IDLE);
        state_o       = state_q;
    end

    always_comb begin
        en_d  = en_q;
        lst_d = lst_q;
        if (!stall_i) begin
            en_d  = '0;
            lst_d = '0;
            for (int s = 1; s < DEPTH; s++) begin
                en_d[s]  = stage_en_o[s-1];
                lst_d[s] = last_en_o[s-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_loop_sched.sv
// Bench for conv_loop_sched: vector table of trip counts, directed stall/reset/
// back-to-back sequences, and randomized runs against a cycle-count model.
`timescale 1ns/1ps
module tb_conv_loop_sched;
    import conv_sched_pkg::*;

    localparam int K_W  = CONV_K_W;
    localparam int D    = CONV_DEPTH;
    localparam int MAXC = 320;

    logic           clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic           ap_start = 1'b0;
    logic [K_W-1:0] k1_bound = '0;
    logic [K_W-1:0] k2_bound = '0;
    logic           stall = 1'b0;
    logic           ap_ready, ap_done, ap_idle;
    logic [K_W-1:0] k1, k2;
    stage_vec_t     stage_en, last_en;
    state_t         dbg_state;

    conv_loop_sched #(.K_W(K_W), .DEPTH(D)) dut (
        .ap_clk_i   (clk),
        .ap_rst_i   (ap_rst),
        .ap_start_i (ap_start),
        .k1_bound_i (k1_bound),
        .k2_bound_i (k2_bound),
        .stall_i    (stall),
        .ap_ready_o (ap_ready),
        .ap_done_o  (ap_done),
        .ap_idle_o  (ap_idle),
        .k1_o       (k1),
        .k2_o       (k2),
        .stage_en_o (stage_en),
        .last_en_o  (last_en),
        .state_o    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [2*K_W-1:0] exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- capture of directed runs ----------------
    int               cap_len = 0;
    logic             r_ready [MAXC];
    logic             r_done  [MAXC];
    logic             r_idle  [MAXC];
    stage_vec_t       r_se    [MAXC];
    logic [2*K_W-1:0] r_k     [MAXC];

    // Cycle 0 presents ap_start; each loop body is one clock cycle.
    task automatic capture(input int ncyc, input int b1, input int b2, input bit hold,
                           input int st_lo, input int st_hi, input int rst_at);
        cap_len = ncyc;
        for (int c = 0; c < ncyc; c++) begin
            ap_start = (c == 0) || hold;
            k1_bound = K_W'(b1);
            k2_bound = K_W'(b2);
            stall    = (c >= st_lo) && (c <= st_hi);
            ap_rst   = (c == rst_at);
            @(negedge clk);
            r_ready[c] = ap_ready;
            r_done[c]  = ap_done;
            r_idle[c]  = ap_idle;
            r_se[c]    = stage_en;
            r_k[c]     = {k1, k2};
            @(posedge clk); #1;
        end
        ap_start = 1'b0;
        stall    = 1'b0;
        ap_rst   = 1'b0;
    endtask

    function automatic logic pick(input int kind, input int c);
        case (kind)
            0:       return r_ready[c];
            1:       return r_done[c];
            2:       return r_idle[c];
            default: return r_se[c][0];
        endcase
    endfunction

    function automatic int first_of(input int kind, input int from);
        for (int c = from; c < cap_len; c++) if (pick(kind, c)) return c;
        return -1;
    endfunction

    function automatic int count_of(input int kind);
        int n = 0;
        for (int c = 0; c < cap_len; c++) if (pick(kind, c)) n++;
        return n;
    endfunction

    // ---------------- randomized run vs. cycle model ----------------
    // Model: t counts unstalled cycles since the start was taken. Iteration i
    // (1-based) is issued at t=i and sits in stage s when t-s == i.
    task automatic rand_run(input int b1, input int b2, input int pct);
        int n, t, cyc, readies, dones, issues;
        bit busy, accepted, finished;
        logic e_rdy, e_dn;
        stage_vec_t exp_se, exp_le;
        logic [14:0] act_v, exp_v;
        n = b1 * b2; t = 0; cyc = 0;
        busy = 1'b0; accepted = 1'b0; finished = 1'b0;
        readies = 0; dones = 0; issues = 0;
        exp_q.delete();
        for (int i = 0; i < b1; i++)
            for (int j = 0; j < b2; j++)
                exp_q.push_back({K_W'(i), K_W'(j)});
        while (!finished && cyc < 4000) begin
            stall = ($urandom_range(0, 99) < pct);
            if (!busy) begin
                ap_start = !accepted;
                k1_bound = K_W'(b1);
                k2_bound = K_W'(b2);
            end else begin
                ap_start = (t >= n) ? 1'($urandom_range(0, 1)) : 1'b1;
                k1_bound = K_W'($urandom_range(0, 255));
                k2_bound = K_W'($urandom_range(0, 255));
            end
            @(negedge clk);
            exp_se = '0;
            exp_le = '0;
            if (busy)
                for (int s = 0; s < D; s++) begin
                    exp_se[s] = (t - s >= 1) && (t - s <= n);
                    exp_le[s] = (t - s == n);
                end
            e_rdy = busy && (t == n) && !stall;
            e_dn  = busy && (t == n + D - 1) && !stall;
            act_v = {ap_ready, ap_done, ap_idle, stage_en, last_en};
            exp_v = {e_rdy, e_dn, !busy, exp_se, exp_le};
            check($sformatf("rand_flags_t%0d", t), longint'(act_v), longint'(exp_v));
            if (busy && t >= 1 && t <= n) begin
                if (exp_q.size() == 0) check("rand_idx_underflow", 1, 0);
                else begin
                    check($sformatf("rand_idx_t%0d", t), longint'({k1, k2}), longint'(exp_q[0]));
                    if (!stall) void'(exp_q.pop_front());
                end
            end
            if (ap_ready) readies++;
            if (ap_done) dones++;
            if (stage_en[0] && !stall) issues++;
            if (!busy && !accepted && !stall) begin
                busy = 1'b1; accepted = 1'b1; t = 1;
            end else if (!busy && accepted) begin
                finished = 1'b1;
            end else if (busy && !stall) begin
                if (t == n + D - 1) busy = 1'b0;
                else t++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ap_start = 1'b0;
        stall    = 1'b0;
        check($sformatf("rand_%0dx%0d_finished", b1, b2), longint'(finished), 1);
        check($sformatf("rand_%0dx%0d_ready_count", b1, b2), readies, 1);
        check($sformatf("rand_%0dx%0d_done_count", b1, b2), dones, 1);
        check($sformatf("rand_%0dx%0d_issue_count", b1, b2), issues, n);
        check($sformatf("rand_%0dx%0d_queue_left", b1, b2), exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int b1;
        int b2;
        int rdy;
        int dn;
        int idl;
    } vec_t;

    vec_t vecs[8];
    logic [2*K_W-1:0] exp_idx[4];

    initial begin
        vecs[0] = '{2, 2, 4, 9, 10};
        vecs[1] = '{1, 3, 3, 8, 9};
        vecs[2] = '{1, 1, 1, 6, 7};
        vecs[3] = '{3, 2, 6, 11, 12};
        vecs[4] = '{0, 5, 1, 1, 2};
        vecs[5] = '{7, 0, 1, 1, 2};
        vecs[6] = '{1, 255, 255, 260, 261};
        vecs[7] = '{4, 1, 4, 9, 10};
        exp_idx[0] = 16'h0000;
        exp_idx[1] = 16'h0001;
        exp_idx[2] = 16'h0100;
        exp_idx[3] = 16'h0101;

        repeat (3) @(posedge clk);
        #1 ap_rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", longint'({ap_ready, ap_done, ap_idle, stage_en, last_en, k1, k2}),
              longint'({1'b0, 1'b0, 1'b1, 6'b0, 6'b0, 8'd0, 8'd0}));
        check("reset_state", longint'(dbg_state), longint'(IDLE));
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            capture(vecs[v].idl + 3, vecs[v].b1, vecs[v].b2, 1'b0, -1, -1, -1);
            check($sformatf("vec%0d_ready_cycle", v), first_of(0, 0), vecs[v].rdy);
            check($sformatf("vec%0d_done_cycle", v), first_of(1, 0), vecs[v].dn);
            check($sformatf("vec%0d_idle_cycle", v), first_of(2, 1), vecs[v].idl);
            check($sformatf("vec%0d_ready_count", v), count_of(0), 1);
            check($sformatf("vec%0d_done_count", v), count_of(1), 1);
            check($sformatf("vec%0d_issues", v), count_of(3), vecs[v].b1 * vecs[v].b2);
            if (vecs[v].b1 == 0 || vecs[v].b2 == 0)
                check($sformatf("vec%0d_zero_stage_en", v), longint'(r_se[1]), 0);
        end

        // 2x2 index order on cycles 1..4
        capture(13, 2, 2, 1'b0, -1, -1, -1);
        for (int c = 1; c <= 4; c++)
            check($sformatf("seq_idx_c%0d", c), longint'(r_k[c]), longint'(exp_idx[c-1]));

        // stall on cycles 2-3
        capture(16, 2, 2, 1'b0, 2, 3, -1);
        check("stall_idx_c4", longint'(r_k[4]), longint'(exp_idx[1]));
        check("stall_ready_cycle", first_of(0, 0), 6);
        check("stall_done_cycle", first_of(1, 0), 11);
        check("stall_stage_en_c2", longint'(r_se[2]), longint'(6'b000011));
        check("stall_stage_en_c3", longint'(r_se[3]), longint'(6'b000011));
        check("stall_ready_count", count_of(0), 1);

        // back-to-back with ap_start held
        capture(18, 1, 3, 1'b1, -1, -1, -1);
        check("b2b_first_done", first_of(1, 0), 8);
        check("b2b_idle_c9", longint'(r_idle[9]), 1);
        check("b2b_busy_c10", longint'(r_idle[10]), 0);
        check("b2b_second_done", first_of(1, 9), 17);
        @(posedge clk); #1;

        // reset in the middle of a 2x4 run
        capture(30, 2, 4, 1'b0, -1, -1, 5);
        check("abort_stage_en_c6", longint'(r_se[6]), 0);
        check("abort_idle_c6", longint'(r_idle[6]), 1);
        check("abort_no_done", count_of(1), 0);

        rand_run(3, 255, 25);
        for (int r = 0; r < 6; r++)
            rand_run($urandom_range(1, 5), $urandom_range(1, 6), 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
